// File: rtl/gate_pkg.sv
// Shared definitions for the gate operand generator: mode and state
// encodings, LFSR tap mask, ALT pattern constants and small helper functions.
package gate_pkg;

    // Pattern modes as seen on the mode input (3 is an alias of ALT)
    localparam logic [1:0] MODE_ALT   = 2'd0;
    localparam logic [1:0] MODE_EXH   = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_ALT_B = 2'd3;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form: taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // ALT bus patterns; the low WIDTH bits are used
    localparam logic [31:0] ALT_EVEN = 32'hAAAA_AAAA;
    localparam logic [31:0] ALT_ODD  = 32'h5555_5555;

    // Even parity over an 8-bit value
    function automatic logic parity8(input logic [7:0] v);
        return ^v;
    endfunction

    // One LFSR step: shift left, feedback is the parity of the tapped bits
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], parity8(q & LFSR_TAPS)};
    endfunction

    // {a_bit,b_bit} = 01,10,11,00 for k[1:0] = 0,1,2,3
    function automatic logic [1:0] bit_pair(input logic [1:0] k);
        return {k[1] ^ k[0], ~k[0]};
    endfunction

endpackage

// File: rtl/gate_lfsr8.sv
// 8-bit Fibonacci LFSR holding the {A,B} operand pair for LFSR mode.
// The value persists across runs; only reset restores SEED.
module gate_lfsr8
    import gate_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv,
    output logic [7:0] q
);

    // Step once per delivered LFSR vector, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (adv) begin
            q <= lfsr_next(q);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/gate_operand_gen.sv
// Operand stimulus generator for the basic gate blocks. On start it emits
// num_vec vectors (A/B buses plus a/b single bits) over a valid/ready
// handshake using one of three patterns: ALT, EXH or LFSR.
module gate_operand_gen
    import gate_pkg::*;
#(
    parameter int         WIDTH = 4,
    parameter int         CNT_W = 16,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             abort,
    input  logic             rdy,
    output logic             vld,
    output logic [WIDTH-1:0] a_bus,
    output logic [WIDTH-1:0] b_bus,
    output logic             a_bit,
    output logic             b_bit,
    output logic [CNT_W-1:0] vec_idx,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0]   IDX_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] AB_ZERO  = {(2*WIDTH){1'b0}};
    // The LFSR pattern only maps onto the buses for 4-bit operands
    localparam bit                 LFSR_OK  = (WIDTH == 32'd4);

    // Latched run parameters and controller state
    logic [1:0]       state_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] num_r;

    // Next-state values
    logic [1:0]         state_s;
    logic [1:0]         mode_s;
    logic [CNT_W-1:0]   num_s;
    logic [CNT_W-1:0]   idx_s;
    logic               vld_s;
    logic [2*WIDTH-1:0] ab_s;
    logic [1:0]         bits_s;
    logic               busy_s;
    logic               done_s;
    logic               adv_s;

    logic [1:0]         eff_mode_s;
    logic               last_s;
    logic [CNT_W-1:0]   idx_inc_s;
    logic [7:0]         lfsr_q_s;

    gate_lfsr8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv_s),
        .q     (lfsr_q_s)
    );

    // {a_bus,b_bus} for vector k in the given (already resolved) mode
    function automatic logic [2*WIDTH-1:0] pattern_ab(
        input logic [1:0]       m,
        input logic [CNT_W-1:0] k,
        input logic [7:0]       lf
    );
        logic [2*WIDTH-1:0] ab;
        case (m)
            MODE_EXH:  ab = (2*WIDTH)'(k);
            MODE_LFSR: ab = (2*WIDTH)'(lf);
            default: begin
                if (k[0]) begin
                    ab = {ALT_ODD[WIDTH-1:0], ~ALT_ODD[WIDTH-1:0]};
                end else begin
                    ab = {ALT_EVEN[WIDTH-1:0], ~ALT_EVEN[WIDTH-1:0]};
                end
            end
        endcase
        return ab;
    endfunction

    assign last_s    = (vec_idx == (num_r - IDX_ONE));
    assign idx_inc_s = vec_idx + IDX_ONE;

    // Resolve the requested mode: 3 aliases ALT, LFSR falls back to EXH off 4-bit
    always_comb begin
        case (mode)
            MODE_EXH: eff_mode_s = MODE_EXH;
            MODE_LFSR: begin
                if (LFSR_OK) begin
                    eff_mode_s = MODE_LFSR;
                end else begin
                    eff_mode_s = MODE_EXH;
                end
            end
            default: eff_mode_s = MODE_ALT;
        endcase
    end

    // Controller: run sequencing, handshake and next output vector
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        num_s   = num_r;
        idx_s   = vec_idx;
        vld_s   = vld;
        ab_s    = {a_bus, b_bus};
        bits_s  = {a_bit, b_bit};
        busy_s  = busy;
        done_s  = 1'b0;
        adv_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_s = eff_mode_s;
                    num_s  = num_vec;
                    idx_s  = IDX_ZERO;
                    if (num_vec != IDX_ZERO) begin
                        state_s = ST_RUN;
                        vld_s   = 1'b1;
                        busy_s  = 1'b1;
                        ab_s    = pattern_ab(eff_mode_s, IDX_ZERO, lfsr_q_s);
                        bits_s  = bit_pair(2'b00);
                    end else begin
                        // Empty run completes immediately without presenting data
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Abort beats a coincident transfer: that vector is dropped
                    state_s = ST_IDLE;
                    vld_s   = 1'b0;
                    busy_s  = 1'b0;
                    idx_s   = IDX_ZERO;
                    ab_s    = AB_ZERO;
                    bits_s  = 2'b00;
                end else if (rdy) begin
                    adv_s = (mode_r == MODE_LFSR);
                    if (last_s) begin
                        state_s = ST_DONE;
                        vld_s   = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        idx_s   = IDX_ZERO;
                        ab_s    = AB_ZERO;
                        bits_s  = 2'b00;
                    end else begin
                        // Back-to-back: next vector appears on the transfer edge
                        idx_s  = idx_inc_s;
                        ab_s   = pattern_ab(mode_r, idx_inc_s, lfsr_next(lfsr_q_s));
                        bits_s = bit_pair(idx_inc_s[1:0]);
                    end
                end else begin
                    // Backpressure: hold every data output stable
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                vld_s   = 1'b0;
                busy_s  = 1'b0;
                idx_s   = IDX_ZERO;
                ab_s    = AB_ZERO;
                bits_s  = 2'b00;
            end
        endcase
    end

    // Register controller state and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_ALT;
            num_r   <= IDX_ZERO;
            vld     <= 1'b0;
            a_bus   <= {WIDTH{1'b0}};
            b_bus   <= {WIDTH{1'b0}};
            a_bit   <= 1'b0;
            b_bit   <= 1'b0;
            vec_idx <= IDX_ZERO;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r        <= state_s;
            mode_r         <= mode_s;
            num_r          <= num_s;
            vld            <= vld_s;
            {a_bus, b_bus} <= ab_s;
            {a_bit, b_bit} <= bits_s;
            vec_idx        <= idx_s;
            busy           <= busy_s;
            done           <= done_s;
        end
    end

endmodule

// File: tb/tb_gate_operand_gen.sv
// Self-checking bench for gate_operand_gen: behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized runs.
module tb_gate_operand_gen;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [CNT_W-1:0] num_vec = 16'd0;
    logic             abort = 1'b0;
    logic             rdy = 1'b0;
    logic             vld;
    logic [WIDTH-1:0] a_bus;
    logic [WIDTH-1:0] b_bus;
    logic             a_bit;
    logic             b_bit;
    logic [CNT_W-1:0] vec_idx;
    logic             busy;
    logic             done;

    gate_operand_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vec(num_vec),
        .abort(abort), .rdy(rdy), .vld(vld), .a_bus(a_bus), .b_bus(b_bus),
        .a_bit(a_bit), .b_bit(b_bit), .vec_idx(vec_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    int m_state = 0;     // 0 idle, 1 presenting vectors, 2 completion cycle
    int m_k = 0;
    int m_num = 0;
    int m_mode = 0;
    int m_lfsr = 'hA5;
    int bit_tab [4] = '{1, 2, 3, 0};

    function automatic int lfsr_step(input int x);
        int fb;
        fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
        return ((x << 1) | fb) & 255;
    endfunction

    function automatic int model_ab();
        if (m_mode == 1) return m_k % 256;
        if (m_mode == 2) return m_lfsr;
        return (m_k % 2 == 0) ? 'hA5 : 'h5A;
    endfunction

    // observations of accepted vectors, for literal pin checks
    int q_ab[$];
    int q_bits[$];
    int q_idx[$];
    int done_cnt = 0;
    int busy_cnt = 0;
    int vld_cnt  = 0;

    // Compare DUT against model mid-cycle, then step the model with current inputs
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_vld", vld, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_a_bus", a_bus, 0);
            chk("rst_b_bus", b_bus, 0);
            chk("rst_bits", {a_bit, b_bit}, 0);
            chk("rst_idx", vec_idx, 0);
            m_state = 0;
            m_lfsr  = 'hA5;
        end else begin
            chk("vld", vld, (m_state == 1) ? 1 : 0);
            chk("busy", busy, (m_state == 1) ? 1 : 0);
            chk("done", done, (m_state == 2) ? 1 : 0);
            if (m_state == 1) begin
                chk("ab", {a_bus, b_bus}, model_ab());
                chk("bits", {a_bit, b_bit}, bit_tab[m_k % 4]);
                chk("vec_idx", vec_idx, m_k);
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (vld) vld_cnt++;
            if (vld && rdy && !abort) begin
                q_ab.push_back(int'({a_bus, b_bus}));
                q_bits.push_back(int'({a_bit, b_bit}));
                q_idx.push_back(int'(vec_idx));
            end
            case (m_state)
                0: if (start) begin
                    m_mode  = (mode == 2'd3) ? 0 : int'(mode);
                    m_num   = int'(num_vec);
                    m_k     = 0;
                    m_state = (num_vec == 16'd0) ? 2 : 1;
                end
                1: if (abort) m_state = 0;
                   else if (rdy) begin
                       if (m_mode == 2) m_lfsr = lfsr_step(m_lfsr);
                       if (m_k == m_num - 1) m_state = 2;
                       else m_k++;
                   end
                default: m_state = 0;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q_ab.delete(); q_bits.delete(); q_idx.delete();
        done_cnt = 0; busy_cnt = 0; vld_cnt = 0;
    endtask

    task automatic start_run(input int md, input int n);
        mode = 2'(md);
        num_vec = 16'(n);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int t = 0;
        while ((busy || done) && t < budget) begin
            if (rnd) begin
                rdy     = ($urandom_range(3, 0) != 0);
                abort   = ($urandom_range(39, 0) == 0);
                start   = ($urandom_range(9, 0) == 0);
                mode    = 2'($urandom_range(3, 0));
                num_vec = 16'($urandom_range(30, 0));
            end
            cyc();
            t++;
        end
        start = 1'b0;
        abort = 1'b0;
        chk("run_in_budget", (t < budget) ? 1 : 0, 1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // LFSR from seed
        rdy = 1'b1;
        clr();
        start_run(2, 3);
        wait_idle(100, 1'b0);
        chk("lfsr_cnt", q_ab.size(), 3);
        if (q_ab.size() == 3) begin
            chk("lfsr_v0", q_ab[0], 'hA5);
            chk("lfsr_v1", q_ab[1], 'h4A);
            chk("lfsr_v2", q_ab[2], 'h95);
        end

        // ALT, 4 vectors
        clr();
        start_run(0, 4);
        wait_idle(100, 1'b0);
        chk("alt_cnt", q_ab.size(), 4);
        if (q_ab.size() == 4) begin
            chk("alt_v0", q_ab[0], 'hA5);
            chk("alt_v1", q_ab[1], 'h5A);
            chk("alt_v2", q_ab[2], 'hA5);
            chk("alt_v3", q_ab[3], 'h5A);
            chk("alt_b0", q_bits[0], 1);
            chk("alt_b1", q_bits[1], 2);
            chk("alt_b2", q_bits[2], 3);
            chk("alt_b3", q_bits[3], 0);
        end
        chk("alt_done_cnt", done_cnt, 1);
        chk("alt_busy_cnt", busy_cnt, 4);

        // EXH, 256 vectors
        clr();
        start_run(1, 256);
        wait_idle(400, 1'b0);
        chk("exh_cnt", q_ab.size(), 256);
        chk("exh_busy_cnt", busy_cnt, 256);
        for (int i = 0; i < q_ab.size(); i++) begin
            chk("exh_vec", q_ab[i], i);
            chk("exh_idx", q_idx[i], i);
        end

        // Backpressure on vector 1
        clr();
        start_run(1, 3);
        cyc();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_idx", vec_idx, 1);
            chk("bp_ab", {a_bus, b_bus}, 1);
            chk("bp_vld", vld, 1);
        end
        rdy = 1'b1;
        wait_idle(100, 1'b0);
        chk("bp_cnt", q_ab.size(), 3);
        if (q_idx.size() == 3) begin
            chk("bp_i0", q_idx[0], 0);
            chk("bp_i1", q_idx[1], 1);
            chk("bp_i2", q_idx[2], 2);
        end

        // Abort at idx 2 with rdy high, then restart
        clr();
        start_run(1, 10);
        cyc();
        cyc();
        chk("ab_pre_idx", vec_idx, 2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("ab_vld", vld, 0);
        chk("ab_busy", busy, 0);
        chk("ab_delivered", q_ab.size(), 2);
        cyc();
        start_run(1, 3);
        chk("ab_restart_idx", vec_idx, 0);
        chk("ab_restart_vld", vld, 1);
        wait_idle(100, 1'b0);
        chk("ab_done_cnt", done_cnt, 1);

        // Empty run
        clr();
        start_run(0, 0);
        wait_idle(100, 1'b0);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_vld_cnt", vld_cnt, 0);

        // Reset mid-run
        start_run(2, 10);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_vld", vld, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ab", {a_bus, b_bus}, 0);
        chk("arst_idx", vec_idx, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // LFSR is reseeded by reset
        clr();
        start_run(2, 2);
        wait_idle(100, 1'b0);
        chk("reseed_cnt", q_ab.size(), 2);
        if (q_ab.size() == 2) chk("reseed_v0", q_ab[0], 'hA5);

        // Randomized runs against the model
        for (int r = 0; r < 40; r++) begin
            rdy = 1'b1;
            start_run($urandom_range(3, 0), $urandom_range(24, 1));
            wait_idle(2000, 1'b1);
            rdy = 1'b0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
